// File: rtl/led_pkg.sv
// Shared constants for the LED blink controller: combine-mode width and encodings.
package led_pkg;
  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_OR    = 2'b00;
  localparam mode_t MODE_AND   = 2'b01;
  localparam mode_t MODE_GATED = 2'b10;
  localparam mode_t MODE_FREE  = 2'b11;
endpackage

// File: rtl/sw_debounce.sv
// One switch channel: 2-flop synchroniser followed by a stable-count debouncer.
module sw_debounce
  import led_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic sw_db
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic s1;
  logic s2;
  logic [CNT_W-1:0] cnt;

  // Any sample matching the accepted level restarts the stability count.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      sw_db <= 1'b0;
    end else begin
      s1 <= sw;
      s2 <= s1;
      if (s2 == sw_db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        sw_db <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// Debounces NUM_SW switches and drives one LED from them under a selectable
// OR / AND / gated-blink / free-blink mode.
module led_blink_ctrl
  import led_pkg::*;
#(
  parameter int NUM_SW      = 3,
  parameter int DEB_CYCLES  = 16,
  parameter int BLINK_DIV_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw,
  input  logic [MODE_W-1:0] mode,
  output logic              out,
  output logic [NUM_SW-1:0] sw_db,
  output logic              blink_tick
);

  logic [BLINK_DIV_W-1:0] pre;
  logic                   phase;
  logic                   out_next;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
    sw_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .sw   (sw[i]),
      .sw_db(sw_db[i])
    );
  end

  // Tick and phase toggle share the edge on which the prescaler wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre        <= '0;
      blink_tick <= 1'b0;
      phase      <= 1'b0;
      out        <= 1'b0;
    end else begin
      pre        <= pre + BLINK_DIV_W'(1);
      blink_tick <= &pre;
      if (&pre) begin
        phase <= ~phase;
      end
      out <= out_next;
    end
  end

  always_comb begin
    out_next = 1'b0;
    case (mode)
      MODE_OR:    out_next = |sw_db;
      MODE_AND:   out_next = &sw_db;
      MODE_GATED: out_next = phase & (|sw_db);
      default:    out_next = phase;
    endcase
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Self-checking bench for led_blink_ctrl: directed literal checks plus a
// cycle-by-cycle comparison against a sliding-window behavioural model.
module tb_led_blink_ctrl;

  localparam int NUM_SW      = 3;
  localparam int DEB_CYCLES  = 4;
  localparam int BLINK_DIV_W = 3;
  localparam int HALF        = 1 << BLINK_DIV_W;

  logic              clk;
  logic              rst;
  logic [NUM_SW-1:0] sw;
  logic [1:0]        mode;
  logic              out;
  logic [NUM_SW-1:0] sw_db;
  logic              blink_tick;

  int tests_run = 0;
  int tests_failed = 0;

  led_blink_ctrl #(
    .NUM_SW     (NUM_SW),
    .DEB_CYCLES (DEB_CYCLES),
    .BLINK_DIV_W(BLINK_DIV_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .mode      (mode),
    .out       (out),
    .sw_db     (sw_db),
    .blink_tick(blink_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [NUM_SW-1:0] s, input logic [1:0] m);
    @(negedge clk);
    rst  = r;
    sw   = s;
    mode = m;
  endtask

  task automatic stepEdges(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic doReset(input logic [NUM_SW-1:0] s, input logic [1:0] m);
    applyStimulus(1'b1, s, m);
    stepEdges(1);
    applyStimulus(1'b0, s, m);
  endtask

  // Behavioural model: a bit is accepted once the synchronised input has
  // disagreed with the accepted level for DEB_CYCLES consecutive edges;
  // synchronised value at edge n is the raw sample from edge n-2.
  int unsigned       m_n;
  logic [NUM_SW-1:0] m_db;
  logic              m_out;
  logic              m_tick;
  logic              m_valid = 1'b0;
  logic [NUM_SW-1:0] hist[$];

  function automatic logic phase_after(input int unsigned k);
    return ((k / HALF) % 2) == 1;
  endfunction

  initial begin : model
    logic              r;
    logic [NUM_SW-1:0] s;
    logic [1:0]        md;
    logic [NUM_SW-1:0] new_db;
    logic              flip;
    forever begin
      @(posedge clk);
      r  = rst;
      s  = sw;
      md = mode;
      if (r) begin
        m_valid = 1'b1;
        m_n     = 0;
        m_db    = '0;
        m_out   = 1'b0;
        m_tick  = 1'b0;
        hist.delete();
        for (int j = 0; j <= DEB_CYCLES; j++) hist.push_back('0);
      end else if (m_valid) begin
        case (md)
          2'b00:   m_out = |m_db;
          2'b01:   m_out = &m_db;
          2'b10:   m_out = phase_after(m_n) & (|m_db);
          default: m_out = phase_after(m_n);
        endcase
        m_n++;
        m_tick = (m_n % HALF) == 0;
        new_db = m_db;
        for (int i = 0; i < NUM_SW; i++) begin
          flip = 1'b1;
          for (int j = 1; j <= DEB_CYCLES; j++)
            if (hist[j][i] == m_db[i]) flip = 1'b0;
          if (flip) new_db[i] = ~m_db[i];
        end
        m_db = new_db;
        hist.push_front(s);
        void'(hist.pop_back());
      end
      #1;
      if (m_valid) begin
        checkOutput("model_out", {31'd0, out}, {31'd0, m_out});
        checkOutput("model_sw_db", {29'd0, sw_db}, {29'd0, m_db});
        checkOutput("model_tick", {31'd0, blink_tick}, {31'd0, m_tick});
      end
    end
  end

  initial begin : stim
    rst  = 1'b1;
    sw   = '0;
    mode = 2'b00;

    // 1: OR mode, sw=010 accepted at edge 6, LED at edge 7.
    doReset(3'b000, 2'b00);
    sw = 3'b010;
    checkOutput("reset_out", {31'd0, out}, 32'd0);
    checkOutput("reset_sw_db", {29'd0, sw_db}, 32'd0);
    checkOutput("reset_tick", {31'd0, blink_tick}, 32'd0);
    stepEdges(5);
    checkOutput("t1_db_edge5", {29'd0, sw_db}, 32'd0);
    checkOutput("t1_out_edge5", {31'd0, out}, 32'd0);
    stepEdges(1);
    checkOutput("t1_db_edge6", {29'd0, sw_db}, 32'b010);
    checkOutput("t1_out_edge6", {31'd0, out}, 32'd0);
    stepEdges(1);
    checkOutput("t1_out_edge7", {31'd0, out}, 32'd1);

    // 2: a 3-cycle glitch is rejected.
    doReset(3'b000, 2'b00);
    sw = 3'b001;
    stepEdges(3);
    applyStimulus(1'b0, 3'b000, 2'b00);
    stepEdges(10);
    checkOutput("t2_db", {29'd0, sw_db}, 32'd0);
    checkOutput("t2_out", {31'd0, out}, 32'd0);

    // 3: AND mode rise, then one switch drops.
    doReset(3'b000, 2'b01);
    sw = 3'b111;
    stepEdges(6);
    checkOutput("t3_db_edge6", {29'd0, sw_db}, 32'b111);
    stepEdges(1);
    checkOutput("t3_out_edge7", {31'd0, out}, 32'd1);
    applyStimulus(1'b0, 3'b011, 2'b01);
    stepEdges(6);
    checkOutput("t3_out_drop6", {31'd0, out}, 32'd1);
    stepEdges(1);
    checkOutput("t3_out_drop7", {31'd0, out}, 32'd0);

    // 4: free-running blink.
    doReset(3'b000, 2'b11);
    stepEdges(7);
    checkOutput("t4_tick7", {31'd0, blink_tick}, 32'd0);
    stepEdges(1);
    checkOutput("t4_tick8", {31'd0, blink_tick}, 32'd1);
    checkOutput("t4_out8", {31'd0, out}, 32'd0);
    stepEdges(1);
    checkOutput("t4_tick9", {31'd0, blink_tick}, 32'd0);
    checkOutput("t4_out9", {31'd0, out}, 32'd1);
    stepEdges(7);
    checkOutput("t4_tick16", {31'd0, blink_tick}, 32'd1);
    stepEdges(1);
    checkOutput("t4_out17", {31'd0, out}, 32'd0);
    stepEdges(7);
    checkOutput("t4_tick24", {31'd0, blink_tick}, 32'd1);

    // 5: gated blink.
    doReset(3'b000, 2'b10);
    stepEdges(40);
    checkOutput("t5_out_idle", {31'd0, out}, 32'd0);
    applyStimulus(1'b0, 3'b001, 2'b10);
    stepEdges(40);
    checkOutput("t5_db_on", {29'd0, sw_db}, 32'b001);
    applyStimulus(1'b0, 3'b000, 2'b10);
    stepEdges(7);
    checkOutput("t5_out_off", {31'd0, out}, 32'd0);

    // 6: reset mid-debounce and mid-blink.
    doReset(3'b000, 2'b11);
    stepEdges(8);
    applyStimulus(1'b0, 3'b001, 2'b11);
    stepEdges(4);
    checkOutput("t6_out_pre", {31'd0, out}, 32'd1);
    applyStimulus(1'b1, 3'b001, 2'b11);
    stepEdges(1);
    checkOutput("t6_rst_out", {31'd0, out}, 32'd0);
    checkOutput("t6_rst_db", {29'd0, sw_db}, 32'd0);
    checkOutput("t6_rst_tick", {31'd0, blink_tick}, 32'd0);
    applyStimulus(1'b0, 3'b001, 2'b11);
    stepEdges(5);
    checkOutput("t6_db_edge5", {29'd0, sw_db}, 32'd0);
    stepEdges(1);
    checkOutput("t6_db_edge6", {29'd0, sw_db}, 32'b001);
    stepEdges(1);
    checkOutput("t6_tick7", {31'd0, blink_tick}, 32'd0);
    stepEdges(1);
    checkOutput("t6_tick8", {31'd0, blink_tick}, 32'd1);

    // Randomised phase: bouncy switches, occasional mode changes and resets.
    begin
      logic [NUM_SW-1:0] s;
      logic [1:0]        m;
      logic              r;
      s = sw;
      m = mode;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(5) == 0) s[$urandom_range(NUM_SW - 1)] ^= 1'b1;
        if ($urandom_range(49) == 0) m = 2'($urandom_range(3));
        r = ($urandom_range(399) == 0);
        applyStimulus(r, s, m);
        stepEdges(1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/led_blink_ctrl.md
Name: led_blink_ctrl

Overview:
Parametrised successor of the switch-to-LED block. It debounces NUM_SW raw switch inputs and combines them under a runtime-selectable mode: OR, AND, switch-gated blink, or free-running blink. A free-running prescaler generates the blink rate. The block sits between board switch pins and a single indicator LED pin, and also exposes the debounced switch vector for other logic.

Parameters:
NUM_SW, 3, number of switch inputs (>=1)
DEB_CYCLES, 16, consecutive stable cycles needed to accept a switch change (>=2)
BLINK_DIV_W, 24, prescaler width; blink half-period = 2^BLINK_DIV_W cycles

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
sw  input  NUM_SW  raw asynchronous switch inputs
mode  input  2  combine mode, quasi-static, not synchronised
out  output  1  registered LED drive
sw_db  output  NUM_SW  debounced switch levels
blink_tick  output  1  one-cycle pulse at each blink phase toggle

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. Sampled only on the clk rising edge; there is no async path.
- Reset values: out=0, sw_db=0, blink_tick=0. Blink phase, prescaler, synchroniser flops and debounce counters all reset to 0.
- Per switch i:
  - 2-flop synchroniser s1->s2.
  - Counter cnt, width clog2(DEB_CYCLES).
  - If s2 == sw_db[i]: cnt<=0.
  - Else if cnt == DEB_CYCLES-1: sw_db[i]<=s2 and cnt<=0.
  - Else: cnt<=cnt+1.
- Debounce latency: take edge 1 as the first edge sampling a new, stable level on sw[i]. sw_db[i] updates on edge DEB_CYCLES+2.
- A glitch that reverts before acceptance resets cnt and leaves sw_db unchanged. Any bounce restarts the count.
- Prescaler: BLINK_DIV_W-bit counter incrementing every cycle and wrapping from all-ones to 0.
  - blink_tick is registered: it is 1 in the cycle after the counter holds all-ones.
  - The blink phase toggles on the same edge that raises blink_tick.
  - First tick after reset: blink_tick is high during cycle 2^BLINK_DIV_W, counting the first post-reset edge as edge 1.
- Mode encoding and out (registered, one cycle after its inputs):
  - 00 MODE_OR: out <= |sw_db
  - 01 MODE_AND: out <= &sw_db
  - 10 MODE_GATED: out <= phase & (|sw_db)
  - 11 MODE_FREE: out <= phase, ignoring switches
- Mode change takes effect on the next edge. The prescaler and phase are never reset by a mode change.
- Simultaneous events:
  - A debounce acceptance and a blink toggle on the same edge are both reflected in out one edge later.
  - rst asserted mid-count discards partial debounce progress and blink phase.
- NUM_SW=1: AND and OR modes are identical.

Decomposition:
- Package led_pkg holds the mode width constant (2) and localparams MODE_OR=2'b00, MODE_AND=2'b01, MODE_GATED=2'b10, MODE_FREE=2'b11.
- Sub-module sw_debounce (parameter DEB_CYCLES): one synchroniser plus counter for one switch. It is instantiated NUM_SW times via generate.
- Prescaler, phase and output mux stay in the top level.

Test Plan:
(Bench parameters: NUM_SW=3, DEB_CYCLES=4, BLINK_DIV_W=3.)
1. Reset, mode=00, sw=3'b010 held from edge 1 -> sw_db=010 at edge 6; out=1 at edge 7; out=0 before edge 7.
2. mode=00, sw[0] pulses 1 for 3 cycles then returns 0 -> sw_db[0] stays 0; out stays 0.
3. mode=01, sw goes 000 -> 111 -> sw_db=111 at edge 6, out=1 at edge 7. Then sw[2] drops to 0 -> out=0 exactly 7 edges after the drop.
4. mode=11, sw=000 from reset -> blink_tick high at cycles 8, 16, 24 (single-cycle). out toggles with period 16, first rising the edge after the first tick.
5. mode=10: sw=000 -> out=0 for 40 cycles. Then sw=001 stable -> out follows phase once sw_db=1. Returning sw to 000 -> out=0 within 7 edges.
6. rst pulsed for 1 cycle mid-debounce (cnt=2) and mid-blink -> all outputs 0 next edge. Debounce restarts with full 6-edge latency; first blink_tick again 8 cycles after reset.
